// File: rtl/window_serializer.sv
// Purpose: buffers two raster rows and serializes each complete 3x3 window as a 9-beat burst (TL..BR).
// Latency: first burst beat is registered one cycle after the window-completing input beat is accepted.
// Backpressure: downstream cannot stall; o_ready drops for the 9 burst cycles so input is throttled instead.
module window_serializer #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_sof,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  col, cur_col;
    logic [RW-1:0]  row, cur_row;
    logic [3:0]     beat, beat_nxt;
    logic           last_win;
    logic           accept, completes, is_last;

    // Row buffers: lb0 holds the previous row, lb1 the row before that.
    logic [7:0]     lb0 [IMG_WIDTH];
    logic [7:0]     lb1 [IMG_WIDTH];
    logic [7:0]     win     [3][3];
    logic [7:0]     win_nxt [3][3];
    logic [7:0]     snap    [9];

    logic           ready_d, valid_d, done_d;
    logic [7:0]     data_d;

    // A start-of-frame beat overrides the counters and is taken as pixel (0,0).
    assign accept    = i_valid && o_ready;
    assign cur_col   = i_sof ? '0 : col;
    assign cur_row   = i_sof ? '0 : row;
    assign completes = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    assign is_last   = (cur_row == RW'(IMG_HEIGHT - 1)) && (cur_col == CW'(IMG_WIDTH - 1));

    // Window shifted one column left, new right column from the row buffers and the incoming pixel.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win[r][1];
            win_nxt[r][1] = win[r][2];
        end
        win_nxt[0][2] = lb1[cur_col];
        win_nxt[1][2] = lb0[cur_col];
        win_nxt[2][2] = i_data;
    end

    // Datapath storage; contents are don't-care until two rows have been seen, so no reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb1[cur_col] <= lb0[cur_col];
            lb0[cur_col] <= i_data;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= win_nxt[r][c];
                end
            end
            if (completes) begin
                for (int k = 0; k < 9; k++) begin
                    snap[k] <= win_nxt[k / 3][k % 3];
                end
            end
        end
    end

    // State, position counters and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            beat         <= '0;
            last_win     <= 1'b0;
            o_ready      <= 1'b0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            state        <= state_nxt;
            beat         <= beat_nxt;
            o_ready      <= ready_d;
            o_valid      <= valid_d;
            o_data       <= data_d;
            o_frame_done <= done_d;
            if (accept) begin
                if (cur_col == CW'(IMG_WIDTH - 1)) begin
                    col <= '0;
                    row <= (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
                end else begin
                    col <= cur_col + CW'(1);
                    row <= cur_row;
                end
                if (completes) begin
                    last_win <= is_last;
                end
            end
        end
    end

    // Next state: a completing beat launches a burst; beat 8 ends it.
    always_comb begin
        state_nxt = state;
        beat_nxt  = '0;
        case (state)
            IDLE: begin
                if (accept && completes) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (beat == 4'd8) begin
                    state_nxt = IDLE;
                end else begin
                    beat_nxt = beat + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register inputs; the first beat bypasses the snapshot since it is latched on the same edge.
    always_comb begin
        ready_d = (state_nxt == IDLE);
        valid_d = (state_nxt == SEND);
        data_d  = '0;
        if (state_nxt == SEND) begin
            data_d = (state == IDLE) ? win_nxt[0][0] : snap[beat_nxt];
        end
        done_d  = (state == SEND) && (beat == 4'd7) && last_win;
    end
endmodule
